// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin front end for a single APB completer.
//
// Ports
//   PCLK, PRESETn        clock, synchronous active-low reset
//   req_valid/req_ready  per-requester request handshake (req_ready is a one-hot accept pulse,
//                        request fields are captured on that cycle's edge)
//   req_addr/req_write/req_wdata/req_strb
//                        packed request fields, requester i in slice i
//   rsp_valid/rsp_rdata/rsp_err
//                        one-hot completion pulse with read data and error flag
//   PSEL..PPROT          APB requester outputs (registered)
//   PREADY/PSLVERR/PRDATA
//                        APB completer inputs
module apb_req_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]              req_write,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   input  logic [2*STRB_WIDTH-1:0] req_strb,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [STRB_WIDTH-1:0]   PSTRB,
   output logic [2:0]              PPROT,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic [DATA_WIDTH-1:0]   PRDATA
);

   localparam int unsigned ALIGN_BITS = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e             state_q;
   logic               last_q;     // index of the requester granted most recently
   logic               cur_idx_q;  // requester owning the transfer in flight
   logic [CNT_W-1:0]   wait_cnt_q;

   logic                  gnt_idx;
   logic                  grant;
   logic                  aligned;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_write;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [STRB_WIDTH-1:0] sel_strb;

   always_comb begin
      // On a tie the requester not granted last wins; a lone requester always wins.
      gnt_idx   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
      // No grant while a response is being presented: keeps one transfer per 4 cycles and
      // guarantees a requester sees its response before its next grant.
      grant     = PRESETn && (state_q == StIdle) && (rsp_valid == 2'b00) && (req_valid != 2'b00);
      req_ready = grant ? {gnt_idx, ~gnt_idx} : 2'b00;
      sel_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      sel_write = req_write[gnt_idx];
      sel_wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      sel_strb  = gnt_idx ? req_strb[2*STRB_WIDTH-1:STRB_WIDTH] : req_strb[STRB_WIDTH-1:0];
      aligned   = (sel_addr & ALIGN_MASK) == '0;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         cur_idx_q  <= 1'b0;
         wait_cnt_q <= '0;
         rsp_valid  <= 2'b00;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         PSTRB      <= '0;
         PPROT      <= 3'b000;
      end else begin
         // Response outputs are single-cycle pulses.
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant) begin
                  last_q    <= gnt_idx;
                  cur_idx_q <= gnt_idx;
                  if (aligned) begin
                     state_q <= StSetup;
                     PSEL    <= 1'b1;
                     PENABLE <= 1'b0;
                     PADDR   <= sel_addr;
                     PWRITE  <= sel_write;
                     PWDATA  <= sel_write ? sel_wdata : '0;
                     PSTRB   <= sel_write ? sel_strb : '0;
                     PPROT   <= sel_addr[ADDR_WIDTH-1] ? 3'b111 : 3'b000;
                  end else begin
                     // Misaligned: answer with an error, leave the bus untouched.
                     rsp_valid <= {gnt_idx, ~gnt_idx};
                     rsp_err   <= 1'b1;
                  end
               end
            end
            StSetup: begin
               state_q    <= StAccess;
               PENABLE    <= 1'b1;
               wait_cnt_q <= '0;
            end
            StAccess: begin
               if (PREADY) begin
                  state_q   <= StIdle;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= {cur_idx_q, ~cur_idx_q};
                  rsp_err   <= PSLVERR;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
               end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q   <= StIdle;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= {cur_idx_q, ~cur_idx_q};
                  rsp_err   <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: self-checking bench for apb_req_arbiter. A transaction-level model
// predicts the round-robin winner, APB field values, access length and response of each request.
module tb_apb_req_arbiter;

   localparam int TIMEOUT = 16;

   logic        PCLK;
   logic        PRESETn;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_write;
   logic [63:0] req_wdata;
   logic [7:0]  req_strb;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        PSEL, PENABLE, PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;
   logic        PREADY, PSLVERR;
   logic [31:0] PRDATA;

   apb_req_arbiter #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(32),
      .STRB_WIDTH(4),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .req_write(req_write),
      .req_wdata(req_wdata),
      .req_strb (req_strb),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PSTRB    (PSTRB),
      .PPROT    (PPROT),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR),
      .PRDATA   (PRDATA)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_errors = 0;

   // Model state and per-transaction stimulus.
   int          m_last;
   logic [15:0] m_paddr;
   logic [1:0]  t_pat;
   int          t_wait;
   logic        t_err;
   logic [31:0] t_rdata;
   logic [15:0] r_addr [2];
   logic        r_write[2];
   logic [31:0] r_wdata[2];
   logic [3:0]  r_strb [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #2;
   endtask

   // Runs one request from an idle, non-response cycle through its response cycle.
   task automatic do_xfer();
      int          win, acc;
      logic        al, to, wr;
      logic [15:0] a;
      logic [1:0]  oh;
      win = (t_pat == 2'b11) ? (1 - m_last) : ((t_pat == 2'b10) ? 1 : 0);
      m_last = win;
      a  = r_addr[win];
      wr = r_write[win];
      al = (a % 4) == 0;
      to = t_wait >= TIMEOUT;
      acc = to ? TIMEOUT : t_wait + 1;
      oh = (win == 1) ? 2'b10 : 2'b01;

      req_valid = t_pat;
      req_addr  = {r_addr[1], r_addr[0]};
      req_write = {r_write[1], r_write[0]};
      req_wdata = {r_wdata[1], r_wdata[0]};
      req_strb  = {r_strb[1], r_strb[0]};
      #1 chk("grant", req_ready, oh);
      tick();
      // Later request changes must not disturb the captured transfer.
      req_valid = 2'b00;
      req_addr  = $urandom;
      req_write = 2'($urandom);
      req_wdata = {$urandom, $urandom};
      req_strb  = 8'($urandom);

      if (!al) begin
         chk("mis_psel", PSEL, 0);
         chk("mis_paddr_hold", PADDR, m_paddr);
         chk("mis_rsp_valid", rsp_valid, oh);
         chk("mis_rsp_err", rsp_err, 1);
         chk("mis_rsp_rdata", rsp_rdata, 0);
      end else begin
         m_paddr = a;
         chk("setup_psel", PSEL, 1);
         chk("setup_penable", PENABLE, 0);
         chk("setup_paddr", PADDR, a);
         chk("setup_pwrite", PWRITE, wr);
         chk("setup_pwdata", PWDATA, wr ? r_wdata[win] : 32'h0);
         chk("setup_pstrb", PSTRB, wr ? r_strb[win] : 4'h0);
         chk("setup_pprot", PPROT, a[15] ? 3'b111 : 3'b000);
         PREADY = 1'b0;
         tick();
         for (int k = 0; k < acc; k++) begin
            PREADY  = !to && (k == t_wait);
            PSLVERR = t_err;
            PRDATA  = t_rdata;
            chk("acc_psel", PSEL, 1);
            chk("acc_penable", PENABLE, 1);
            chk("acc_paddr", PADDR, a);
            chk("acc_pwdata", PWDATA, wr ? r_wdata[win] : 32'h0);
            chk("acc_rsp_idle", rsp_valid, 0);
            tick();
         end
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         PRDATA  = $urandom;
         chk("end_psel", PSEL, 0);
         chk("end_penable", PENABLE, 0);
         chk("end_paddr_hold", PADDR, a);
         chk("rsp_valid", rsp_valid, oh);
         chk("rsp_err", rsp_err, to ? 1'b1 : t_err);
         chk("rsp_rdata", rsp_rdata, (to || wr) ? 32'h0 : t_rdata);
      end
      // No grant may be issued in the response cycle.
      req_valid = 2'b11;
      #1 chk("no_grant_in_rsp", req_ready, 0);
      req_valid = 2'b00;
      tick();
      chk("rsp_pulse_end", rsp_valid, 0);
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s);
      r_addr[i]  = a;
      r_write[i] = w;
      r_wdata[i] = d;
      r_strb[i]  = s;
   endtask

   initial begin
      PRESETn   = 1'b0;
      req_valid = 2'b11;
      req_addr  = 32'h0020_0010;
      req_write = 2'b00;
      req_wdata = '0;
      req_strb  = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      tick();
      tick();
      // Reset state, including req_ready held low despite pending requests.
      chk("rst_req_ready", req_ready, 0);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_pstrb", PSTRB, 0);
      chk("rst_pprot", PPROT, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      m_last  = 1;
      m_paddr = 16'h0;

      // Continuous tie with PREADY=1: alternating grants every 4 cycles.
      PRESETn = 1'b1;
      PREADY  = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         chk("rr_ready", req_ready, (c % 4 != 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10));
         chk("rr_rsp", rsp_valid, (c % 4 != 3) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10));
         tick();
      end
      req_valid = 2'b00;
      PREADY    = 1'b0;
      m_last    = 1;
      m_paddr   = 16'h0020;
      tick();

      // Write from requester 0, zero wait states.
      set_req(0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF);
      t_pat = 2'b01; t_wait = 0; t_err = 1'b0; t_rdata = 32'h0;
      do_xfer();
      // Read from requester 1 in the upper half, two wait states.
      set_req(1, 16'h8004, 1'b0, 32'hCAFEF00D, 4'hA);
      t_pat = 2'b10; t_wait = 2; t_err = 1'b0; t_rdata = 32'h12345678;
      do_xfer();
      // Misaligned request.
      set_req(0, 16'h0002, 1'b1, 32'h11111111, 4'hF);
      t_pat = 2'b01; t_wait = 0;
      do_xfer();
      // Timeout, then a slave error.
      set_req(0, 16'h0100, 1'b0, 32'h0, 4'h0);
      t_pat = 2'b01; t_wait = TIMEOUT + 5; t_rdata = 32'hFFFF0000;
      do_xfer();
      set_req(0, 16'h0104, 1'b1, 32'h55AA55AA, 4'h3);
      t_pat = 2'b01; t_wait = 1; t_err = 1'b1;
      do_xfer();
      // Wait count one short of the timeout still completes normally.
      set_req(1, 16'h0200, 1'b0, 32'h0, 4'h0);
      t_pat = 2'b10; t_wait = TIMEOUT - 1; t_err = 1'b0; t_rdata = 32'hA5A5A5A5;
      do_xfer();

      // Reset in the second ACCESS cycle aborts without a response.
      req_valid = 2'b01;
      req_addr  = 32'h0000_0040;
      req_write = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      chk("abort_in_access", PENABLE, 1);
      PRESETn = 1'b0;
      tick();
      chk("abort_psel", PSEL, 0);
      chk("abort_penable", PENABLE, 0);
      chk("abort_rsp", rsp_valid, 0);
      PRESETn = 1'b1;
      chk("abort_no_late_rsp", rsp_valid, 0);
      m_last  = 1;
      m_paddr = 16'h0;
      set_req(0, 16'h0300, 1'b0, 32'h0, 4'h0);
      set_req(1, 16'h0304, 1'b0, 32'h0, 4'h0);
      t_pat = 2'b11; t_wait = 0; t_err = 1'b0; t_rdata = 32'h0BADF00D;
      do_xfer();

      // Randomised transactions.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 2; i++) begin
            r_addr[i] = 16'($urandom);
            if ($urandom_range(0, 3) != 0) r_addr[i][1:0] = 2'b00;
            r_write[i] = 1'($urandom);
            r_wdata[i] = $urandom;
            r_strb[i]  = 4'($urandom);
         end
         t_pat   = 2'($urandom_range(1, 3));
         t_wait  = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1)
                                               : $urandom_range(0, 4);
         t_err   = 1'($urandom);
         t_rdata = $urandom;
         do_xfer();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
